reaction_timer: RTL

REACTION_TIMER -- requirements
Module: reaction_timer

---
 rtl/reaction_timer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/reaction_timer.sv
// reaction_timer: measures driver reaction time after the start lights go out.
// Arms when the light bar is full, starts counting milliseconds (BCD) when it
// clears, and stops on the first button press edge. A press before lights-out
// is a jump start. The light bar is only observed, never driven.
module reaction_timer #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  lights,
  input  logic        btn,
  input  logic        clr,
  output logic [15:0] bcd,
  output logic        done,
  output logic        foul,
  output logic        ovf,
  output logic        busy
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    TIMING,
    DONE,
    FOUL
  } state_t;

  state_t          state;
  logic            btn_q;
  logic [PW-1:0]   prescaler;
  logic            btn_edge;
  logic            ms_step;

  // Four-digit decimal increment with per-digit carry; caller handles 9999.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    logic [3:0]  d;
    r = '0;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = v[4*i +: 4];
      if (c && d == 4'd9) begin
        r[4*i +: 4] = 4'd0;
      end else if (c) begin
        r[4*i +: 4] = d + 4'd1;
        c = 1'b0;
      end else begin
        r[4*i +: 4] = d;
      end
    end
    return r;
  endfunction

  assign btn_edge = btn & ~btn_q;
  assign ms_step  = (prescaler == PRE_LAST);

  // Status flags are pure decodes of the registered state.
  assign done = (state == DONE);
  assign foul = (state == FOUL);
  assign busy = (state == ARMED) || (state == TIMING);

  // Button history register for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    if (rst) btn_q <= 1'b0;
    else     btn_q <= btn;
  end

  // Main FSM with the prescaler, BCD counter and overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prescaler <= '0;
      bcd       <= '0;
      ovf       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (clr) begin
            bcd <= '0;
            ovf <= 1'b0;
          end
          if (lights == 8'hFF) state <= ARMED;
        end

        ARMED: begin
          // A press wins over a simultaneous lights-out.
          if (btn_edge) begin
            state <= FOUL;
            bcd   <= '0;
          end else if (lights == 8'h00) begin
            state     <= TIMING;
            bcd       <= '0;
            prescaler <= '0;
            ovf       <= 1'b0;
          end
        end

        TIMING: begin
          // The stopping press suppresses any step landing on the same edge.
          if (btn_edge) begin
            state <= DONE;
          end else if (ms_step) begin
            prescaler <= '0;
            if (bcd == 16'h9999) ovf <= 1'b1;
            else                 bcd <= bcd_inc(bcd);
          end else begin
            prescaler <= prescaler + PW'(1);
          end
        end

        DONE, FOUL: begin
          if (clr) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
